sram_like_arbiter: RTL and testbench



---
 rtl/sram_like_arbiter.sv | 165 ++++++++++++++++
 tb/tb_sram_like_arbiter.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// sram_like_arbiter
//
// Shares one sram-like memory port between the instruction-fetch requester
// (inst side) and the load/store requester (data side). A request is accepted
// in IDLE and its payload is latched. The latched request is then presented
// on the shared port until the port accepts it. The arbiter then waits for the
// single outstanding transaction to complete and routes data_ok back to the
// side that owns it.
//
// Parameters
//   ADDR_W     address width
//   DATA_W     data width
//   DATA_PRIO  1: data side wins simultaneous requests
//              0: round-robin on simultaneous requests (alternate vs last owner)
//
// Ports
//   clk, reset                    clock, synchronous active-high reset
//   inst_sram_*  / data_sram_*    requester-side sram-like ports
//     req/wr/size/addr/wdata      request in, held until *_addr_ok
//     addr_ok                     request accepted (combinational, IDLE only)
//     data_ok/rdata               completion and read data (rdata broadcast)
//   sram_*                        shared port towards the sram-like/AXI bridge
//     req/wr/size/addr/wdata      latched request, stable until sram_addr_ok
//     addr_ok/data_ok/rdata       bridge accept, completion, read data
// -----------------------------------------------------------------------------
module sram_like_arbiter #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter bit DATA_PRIO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,

  input  logic              inst_sram_req,
  input  logic              inst_sram_wr,
  input  logic [1:0]        inst_sram_size,
  input  logic [ADDR_W-1:0] inst_sram_addr,
  input  logic [DATA_W-1:0] inst_sram_wdata,
  output logic              inst_sram_addr_ok,
  output logic              inst_sram_data_ok,
  output logic [DATA_W-1:0] inst_sram_rdata,

  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata,

  output logic              sram_req,
  output logic              sram_wr,
  output logic [1:0]        sram_size,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic              sram_addr_ok,
  input  logic              sram_data_ok,
  input  logic [DATA_W-1:0] sram_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  logic              owner;       // 0 = inst, 1 = data
  logic              last_owner;  // winner of the previous acceptance
  logic              req_wr;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              grant_inst;
  logic              grant_data;
  logic              done;

  // Winner selection. An acceptance during a reset cycle would be discarded
  // by the reset, so nothing is acknowledged while reset is high.
  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state == IDLE && !reset) begin
      if (inst_sram_req && data_sram_req) begin
        if (DATA_PRIO) begin
          grant_data = 1'b1;
        end else if (last_owner) begin
          grant_inst = 1'b1;
        end else begin
          grant_data = 1'b1;
        end
      end else begin
        grant_inst = inst_sram_req;
        grant_data = data_sram_req;
      end
    end
  end

  assign inst_sram_addr_ok = grant_inst;
  assign data_sram_addr_ok = grant_data;

  // Completion only counts in DATA; a data_ok seen in IDLE or together with
  // addr_ok in ADDR belongs to nobody and is dropped.
  assign done              = (state == DATA) && sram_data_ok && !reset;
  assign inst_sram_data_ok = done && !owner;
  assign data_sram_data_ok = done && owner;

  // Read data is broadcast; only the owner's data_ok qualifies it.
  assign inst_sram_rdata   = sram_rdata;
  assign data_sram_rdata   = sram_rdata;

  assign sram_req          = (state == ADDR);
  assign sram_wr           = req_wr;
  assign sram_size         = req_size;
  assign sram_addr         = req_addr;
  assign sram_wdata        = req_wdata;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      req_wr     <= 1'b0;
      req_size   <= 2'd0;
      req_addr   <= '0;
      req_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_inst || grant_data) begin
            owner      <= grant_data;
            last_owner <= grant_data;
            state      <= ADDR;
            if (grant_data) begin
              req_wr    <= data_sram_wr;
              req_size  <= data_sram_size;
              req_addr  <= data_sram_addr;
              req_wdata <= data_sram_wdata;
            end else begin
              req_wr    <= inst_sram_wr;
              req_size  <= inst_sram_size;
              req_addr  <= inst_sram_addr;
              req_wdata <= inst_sram_wdata;
            end
          end
        end
        ADDR: begin
          if (sram_addr_ok) state <= DATA;
        end
        DATA: begin
          if (sram_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// -----------------------------------------------------------------------------
// tb_sram_like_arbiter
//
// Two arbiter instances (DATA_PRIO=1 and DATA_PRIO=0) share all inputs; a
// select picks which one drives the slave model and the monitor. Requests are
// queued per side, expected transactions are queued in hand-derived grant
// order, and a monitor compares grants, shared-port payload and completions
// against that queue whenever the DUT presents them.
// -----------------------------------------------------------------------------
module tb_sram_like_arbiter;

  typedef struct {
    logic        owner;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;

  logic        clk;
  logic        reset;
  logic        sel_rr;
  int          cyc;
  int          n_checks;
  int          n_pass;

  // requester inputs
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;

  // shared-port inputs: automatic slave model or manual drive
  logic        slave_en;
  logic        s_addr_ok, s_data_ok, m_addr_ok, m_data_ok;
  logic [31:0] s_rdata, m_rdata;
  logic        sram_addr_ok, sram_data_ok;
  logic [31:0] sram_rdata;
  int          addr_delay, data_delay;

  assign sram_addr_ok = slave_en ? s_addr_ok : m_addr_ok;
  assign sram_data_ok = slave_en ? s_data_ok : m_data_ok;
  assign sram_rdata   = slave_en ? s_rdata   : m_rdata;

  // per-instance outputs
  logic        p_inst_addr_ok, p_inst_data_ok, p_data_addr_ok, p_data_data_ok;
  logic [31:0] p_inst_rdata, p_data_rdata;
  logic        p_sram_req, p_sram_wr;
  logic [1:0]  p_sram_size;
  logic [31:0] p_sram_addr, p_sram_wdata;
  logic        r_inst_addr_ok, r_inst_data_ok, r_data_addr_ok, r_data_data_ok;
  logic [31:0] r_inst_rdata, r_data_rdata;
  logic        r_sram_req, r_sram_wr;
  logic [1:0]  r_sram_size;
  logic [31:0] r_sram_addr, r_sram_wdata;

  // selected instance outputs
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sram_req, sram_wr;
  logic [1:0]  sram_size;
  logic [31:0] sram_addr, sram_wdata;

  assign inst_addr_ok = sel_rr ? r_inst_addr_ok : p_inst_addr_ok;
  assign inst_data_ok = sel_rr ? r_inst_data_ok : p_inst_data_ok;
  assign inst_rdata   = sel_rr ? r_inst_rdata   : p_inst_rdata;
  assign data_addr_ok = sel_rr ? r_data_addr_ok : p_data_addr_ok;
  assign data_data_ok = sel_rr ? r_data_data_ok : p_data_data_ok;
  assign data_rdata   = sel_rr ? r_data_rdata   : p_data_rdata;
  assign sram_req     = sel_rr ? r_sram_req     : p_sram_req;
  assign sram_wr      = sel_rr ? r_sram_wr      : p_sram_wr;
  assign sram_size    = sel_rr ? r_sram_size    : p_sram_size;
  assign sram_addr    = sel_rr ? r_sram_addr    : p_sram_addr;
  assign sram_wdata   = sel_rr ? r_sram_wdata   : p_sram_wdata;

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1'b1)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(p_inst_addr_ok),
    .inst_sram_data_ok(p_inst_data_ok), .inst_sram_rdata(p_inst_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(p_data_addr_ok),
    .data_sram_data_ok(p_data_data_ok), .data_sram_rdata(p_data_rdata),
    .sram_req(p_sram_req), .sram_wr(p_sram_wr), .sram_size(p_sram_size),
    .sram_addr(p_sram_addr), .sram_wdata(p_sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok),
    .sram_rdata(sram_rdata)
  );

  sram_like_arbiter #(.ADDR_W(32), .DATA_W(32), .DATA_PRIO(1'b0)) dut_rr (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wdata(inst_sram_wdata), .inst_sram_addr_ok(r_inst_addr_ok),
    .inst_sram_data_ok(r_inst_data_ok), .inst_sram_rdata(r_inst_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_addr_ok(r_data_addr_ok),
    .data_sram_data_ok(r_data_data_ok), .data_sram_rdata(r_data_rdata),
    .sram_req(r_sram_req), .sram_wr(r_sram_wr), .sram_size(r_sram_size),
    .sram_addr(r_sram_addr), .sram_wdata(r_sram_wdata),
    .sram_addr_ok(sram_addr_ok), .sram_data_ok(sram_data_ok),
    .sram_rdata(sram_rdata)
  );

  // queues shared between stimulus, requester drivers, slave and monitor
  txn_t inst_q[$];
  txn_t data_q[$];
  txn_t exp_q[$];
  logic [31:0] slave_rdata_q[$];
  int   acc_log[$];
  int   hs_log[$];
  int   dok_log[$];
  int   inst_dok_cnt, data_dok_cnt;
  txn_t cur;
  bit   has_cur;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic txn_t mk(input logic owner, input logic wr, input logic [1:0] size,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata);
    txn_t t;
    t.owner = owner; t.wr = wr; t.size = size;
    t.addr = addr; t.wdata = wdata; t.rdata = rdata;
    return t;
  endfunction

  task automatic issue(input txn_t t);
    if (t.owner) data_q.push_back(t);
    else inst_q.push_back(t);
  endtask

  task automatic expect_txn(input txn_t t);
    exp_q.push_back(t);
    slave_rdata_q.push_back(t.rdata);
  endtask

  task automatic clear_logs();
    acc_log.delete(); hs_log.delete(); dok_log.delete();
    inst_dok_cnt = 0; data_dok_cnt = 0;
  endtask

  task automatic do_reset(input logic rr);
    tick();
    reset = 1'b1;
    sel_rr = rr;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    inst_q.delete(); data_q.delete(); exp_q.delete(); slave_rdata_q.delete();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      tick();
      if (exp_q.size() == 0 && !has_cur && inst_q.size() == 0 && data_q.size() == 0)
        done = 1'b1;
    end
    check({name, "_complete"}, done, 1'b1);
  endtask

  task automatic wait_req(input string name, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (sram_req) seen = 1'b1;
    end
    check({name, "_sram_req_seen"}, seen, 1'b1);
  endtask

  // inst-side requester: holds req and payload until addr_ok
  initial begin
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0;
    inst_sram_addr = '0; inst_sram_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (inst_q.size() > 0) begin
        inst_sram_req   = 1'b1;
        inst_sram_wr    = inst_q[0].wr;
        inst_sram_size  = inst_q[0].size;
        inst_sram_addr  = inst_q[0].addr;
        inst_sram_wdata = inst_q[0].wdata;
      end else begin
        inst_sram_req = 1'b0;
      end
      @(negedge clk);
      if (inst_sram_req && inst_addr_ok && inst_q.size() > 0) inst_q.delete(0);
    end
  end

  // data-side requester
  initial begin
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd0;
    data_sram_addr = '0; data_sram_wdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (data_q.size() > 0) begin
        data_sram_req   = 1'b1;
        data_sram_wr    = data_q[0].wr;
        data_sram_size  = data_q[0].size;
        data_sram_addr  = data_q[0].addr;
        data_sram_wdata = data_q[0].wdata;
      end else begin
        data_sram_req = 1'b0;
      end
      @(negedge clk);
      if (data_sram_req && data_addr_ok && data_q.size() > 0) data_q.delete(0);
    end
  end

  // slave: addr_ok after addr_delay cycles of sram_req, data_ok data_delay
  // cycles after the data phase begins
  initial begin
    bit ph;
    int wcnt;
    s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    ph = 1'b0; wcnt = 0;
    forever begin
      @(posedge clk);
      #1;
      s_addr_ok = 1'b0;
      s_data_ok = 1'b0;
      if (reset || !slave_en) begin
        ph = 1'b0; wcnt = 0;
      end else if (!ph) begin
        if (sram_req) begin
          if (wcnt == addr_delay) begin
            s_addr_ok = 1'b1; ph = 1'b1; wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end else begin
        if (wcnt == data_delay) begin
          s_data_ok = 1'b1;
          s_rdata = (slave_rdata_q.size() > 0) ? slave_rdata_q.pop_front() : 32'h0;
          ph = 1'b0; wcnt = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  // monitor: compares whatever the DUT presents against the expected queue
  initial begin
    has_cur = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        has_cur = 1'b0;
      end else begin
        if (inst_addr_ok || data_addr_ok) begin
          check("single_grant", inst_addr_ok && data_addr_ok, 1'b0);
          check("accept_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            cur = exp_q.pop_front();
            check("grant_owner", data_addr_ok, cur.owner);
            has_cur = 1'b1;
            acc_log.push_back(cyc);
          end
        end
        if (sram_req) begin
          check("req_outstanding", has_cur, 1'b1);
          check("sram_payload", {sram_wr, sram_size, sram_addr, sram_wdata},
                {cur.wr, cur.size, cur.addr, cur.wdata});
          if (sram_addr_ok) hs_log.push_back(cyc);
        end
        if (inst_data_ok || data_data_ok) begin
          check("single_data_ok", inst_data_ok && data_data_ok, 1'b0);
          check("data_ok_expected", has_cur, 1'b1);
          check("data_ok_owner", data_data_ok, cur.owner);
          if (!cur.wr) begin
            check("inst_rdata", inst_rdata, cur.rdata);
            check("data_rdata", data_rdata, cur.rdata);
          end
          if (data_data_ok) data_dok_cnt++;
          else inst_dok_cnt++;
          dok_log.push_back(cyc);
          has_cur = 1'b0;
        end
      end
    end
  end

  initial begin
    txn_t t0, t1, t2, t3;
    n_checks = 0; n_pass = 0;
    reset = 1'b1; sel_rr = 1'b0; slave_en = 1'b1;
    addr_delay = 0; data_delay = 0;
    m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    clear_logs();

    // reset state
    repeat (3) tick();
    @(negedge clk);
    check("reset_sram_req", sram_req, 1'b0);
    check("reset_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
    check("reset_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    check("reset_payload", {sram_wr, sram_size, sram_addr, sram_wdata}, '0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge clk);
    check("idle_sram_req", sram_req, 1'b0);

    // single data read: addr_ok at T0, sram_req at T1, data_ok at T3
    data_delay = 1;
    clear_logs();
    t0 = mk(1'b1, 1'b0, 2'd2, 32'h1000_0004, 32'h0, 32'hDEAD_BEEF);
    issue(t0); expect_txn(t0);
    wait_done("single_read", 30);
    check("single_read_req_latency", hs_log[0] - acc_log[0], 1);
    check("single_read_data_latency", dok_log[0] - acc_log[0], 3);
    check("single_read_data_pulses", data_dok_cnt, 1);
    check("single_read_inst_pulses", inst_dok_cnt, 0);

    // simultaneous requests, fixed data priority, best-case slave
    data_delay = 0;
    @(negedge clk);
    clear_logs();
    t0 = mk(1'b1, 1'b0, 2'd2, 32'h1000_0008, 32'h0, 32'h0BAD_F00D);
    t1 = mk(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'h1234_5678);
    issue(t1); issue(t0);
    expect_txn(t0); expect_txn(t1);
    wait_done("prio", 40);
    check("prio_accepts", acc_log.size(), 2);
    check("prio_next_accept", acc_log[1] - acc_log[0], 3);
    check("prio_best_data_latency", dok_log[0] - acc_log[0], 2);

    // slave stalls addr_ok for 5 cycles; inst waits behind it
    addr_delay = 5;
    @(negedge clk);
    clear_logs();
    t0 = mk(1'b1, 1'b0, 2'd2, 32'h1000_0200, 32'h0, 32'hCAFE_0001);
    t1 = mk(1'b0, 1'b0, 2'd2, 32'h0000_0300, 32'h0, 32'hCAFE_0002);
    issue(t0); issue(t1);
    expect_txn(t0); expect_txn(t1);
    wait_done("stall", 60);
    check("stall_req_cycles", hs_log[0] - acc_log[0], 6);
    check("stall_next_accept", acc_log[1] - acc_log[0], 8);

    // byte write from the data side
    addr_delay = 0;
    @(negedge clk);
    clear_logs();
    t0 = mk(1'b1, 1'b1, 2'd0, 32'h0000_0003, 32'h0000_00AB, 32'h0);
    issue(t0); expect_txn(t0);
    wait_done("write", 30);
    check("write_handshakes", hs_log.size(), 1);
    check("write_data_pulses", data_dok_cnt, 1);
    check("write_inst_pulses", inst_dok_cnt, 0);

    // round-robin instance, both sides requesting continuously
    do_reset(1'b1);
    @(negedge clk);
    clear_logs();
    t0 = mk(1'b0, 1'b0, 2'd2, 32'h0000_0100, 32'h0, 32'hA0A0_0001);
    t1 = mk(1'b0, 1'b0, 2'd2, 32'h0000_0104, 32'h0, 32'hA0A0_0002);
    t2 = mk(1'b1, 1'b0, 2'd2, 32'h1000_0100, 32'h0, 32'hB0B0_0001);
    t3 = mk(1'b1, 1'b0, 2'd2, 32'h1000_0104, 32'h0, 32'hB0B0_0002);
    issue(t0); issue(t1); issue(t2); issue(t3);
    expect_txn(t0); expect_txn(t2); expect_txn(t1); expect_txn(t3);
    wait_done("rr", 80);
    check("rr_accepts", acc_log.size(), 4);
    check("rr_inst_pulses", inst_dok_cnt, 2);
    check("rr_data_pulses", data_dok_cnt, 2);

    // manually driven shared port on the priority instance
    slave_en = 1'b0;
    do_reset(1'b0);

    // data_ok while idle is ignored
    tick();
    m_data_ok = 1'b1; m_rdata = 32'h5555_5555;
    @(negedge clk);
    check("idle_spurious_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    tick();
    m_data_ok = 1'b0;
    check("idle_no_state_change", sram_req, 1'b0);

    // addr_ok and data_ok together in ADDR: only addr_ok counts
    @(negedge clk);
    clear_logs();
    t0 = mk(1'b1, 1'b0, 2'd2, 32'h2000_0010, 32'h0, 32'h2222_2222);
    issue(t0); expect_txn(t0);
    wait_req("both_ok", 10);
    m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = 32'h1111_1111;
    @(negedge clk);
    check("both_ok_no_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h2222_2222;
    @(negedge clk);
    check("both_ok_later_data_ok", data_data_ok, 1'b1);
    tick();
    m_data_ok = 1'b0;
    check("both_ok_data_pulses", data_dok_cnt, 1);

    // reset while waiting in DATA; late data_ok dropped
    @(negedge clk);
    t0 = mk(1'b1, 1'b0, 2'd2, 32'h2000_0020, 32'h0, 32'h0);
    issue(t0); expect_txn(t0);
    wait_req("rst_data", 10);
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0;
    reset = 1'b1;
    tick();
    check("rst_data_sram_req", sram_req, 1'b0);
    reset = 1'b0;
    m_data_ok = 1'b1; m_rdata = 32'h3333_3333;
    @(negedge clk);
    check("rst_data_late_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    tick();
    m_data_ok = 1'b0;

    // arbiter is idle again: a fresh inst read goes straight through
    @(negedge clk);
    clear_logs();
    t1 = mk(1'b0, 1'b0, 2'd2, 32'h0000_0400, 32'h0, 32'h4444_4444);
    issue(t1); expect_txn(t1);
    wait_req("post_rst", 10);
    m_addr_ok = 1'b1;
    tick();
    m_addr_ok = 1'b0; m_data_ok = 1'b1; m_rdata = 32'h4444_4444;
    @(negedge clk);
    check("post_rst_inst_data_ok", inst_data_ok, 1'b1);
    tick();
    m_data_ok = 1'b0;
    check("post_rst_accepts", acc_log.size(), 1);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
